vedic_dot_acc: RTL and testbench
================================

// Module: vedic_dot_acc
// PURPOSE
//   Downstream consumer of the vedic_mult product bus.
//   Accumulates a job of LEN unsigned products, taken over a valid/ready
//   stream, into a single dot-product result.
//   Presents the result on a valid/ready output toward the AXI-side result
//   register. Sits between the registered multiplier output and the CSR and
//   readback logic.
// PARAMETERS
//   WIDTH      8   operand width of the upstream multiplier; product is 2*WIDTH bits
//   ACC_WIDTH  24  accumulator/result width; must be >= 2*WIDTH
//   LEN_WIDTH  8   width of the job-length field (max job = 2**LEN_WIDTH-1 products)
// PORTS
//   clk        in   1            single clock, all logic rising-edge
//   rst        in   1            asynchronous, active-high reset
//   start      in   1            one-cycle job launch pulse, sampled only in IDLE
//   len        in   LEN_WIDTH    number of products in the job, sampled with start
//   s_valid    in   1            upstream product valid
//   s_ready    out  1            this block accepts a product
//   s_product  in   2*WIDTH      unsigned product from vedic_mult
//   m_valid    out  1            result valid
//   m_ready    in   1            downstream accepts result
//   m_result   out  ACC_WIDTH    accumulated sum
//   overflow   out  1            sticky: a carry left ACC_WIDTH during the current job
//   busy       out  1            high in ACCUM or DONE
// BEHAVIOUR
//   - Reset (async, rst=1):
//     - state=IDLE; acc=0; cnt=0.
//     - s_ready=0, m_valid=0, m_result=0, overflow=0, busy=0.
//   - FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded
//     from state. There is no combinational path from input to output.
//   - IDLE:
//     - s_ready=0.
//     - start=1 with len!=0: acc<=0, overflow<=0, cnt<=len, go to ACCUM.
//     - start=1 with len==0: acc<=0, overflow<=0, go directly to DONE.
//       m_valid rises the next cycle with result 0.
//   - ACCUM:
//     - s_ready=1.
//     - A beat is accepted when s_valid&&s_ready.
//     - On each beat: acc <= acc + zero-extended s_product; cnt <= cnt-1.
//     - When cnt==1 and a beat is accepted, go to DONE.
//     - Gaps in s_valid only stall; they never end the job.
//   - DONE:
//     - s_ready=0; m_valid=1; m_result=acc.
//     - m_result and overflow hold stable while m_valid && !m_ready.
//     - m_valid && m_ready: go to IDLE and drop m_valid in the same edge.
//   - start outside IDLE is ignored, with no effect on acc, cnt or len.
//   - Latency: m_valid asserts 1 cycle after the last accepted beat.
//     Back-to-back jobs need at least one IDLE cycle between them.
//   - Arithmetic: unsigned, computed at ACC_WIDTH+1 bits.
//     - A set bit ACC_WIDTH sets overflow.
//     - Without the optional feature, acc wraps modulo 2**ACC_WIDTH.
//   - Reset asserted mid-job aborts it immediately. No m_valid is produced
//     for the aborted job.
// CONFIGURATION
//   DOT_ACC_SATURATE_EN
//   - Defined: on overflow, acc clamps to {ACC_WIDTH{1'b1}} and stays
//     clamped for the rest of the job. overflow is still set.
//   - Undefined: acc wraps. overflow is set identically.
// TESTING
//   1. Basic job: len=3, products 10,20,30 back-to-back.
//      -> m_valid 1 cycle after the 3rd beat, m_result=60, overflow=0.
//   2. Stalls and backpressure: len=2, products 5 and 7 separated by 4 idle
//      cycles; m_ready held low 5 cycles.
//      -> m_result=12 held stable; m_valid drops the cycle after m_ready=1.
//   3. Empty job: start with len=0.
//      -> m_valid next cycle, m_result=0; s_ready never asserts.
//   4. Overflow, ACC_WIDTH=16, WIDTH=8: products 0xFFFF, 0x0002.
//      -> without DOT_ACC_SATURATE_EN: m_result=0x0001, overflow=1.
//      -> with DOT_ACC_SATURATE_EN: m_result=0xFFFF, overflow=1.
//   5. Reset mid-job: len=4, rst pulsed after 2 beats.
//      -> all outputs 0 asynchronously, state IDLE, no m_valid.
//      -> a new len=1 job with product 9 gives m_result=9.
//   6. start in ACCUM or DONE with a new len.
//      -> ignored; the current job completes with its original length and sum.

Source files
------------

// File: rtl/vedic_dot_acc_if.sv
// Stream/result bundle for vedic_dot_acc.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid and data
// stable until that edge, and ready never depends combinationally on valid.
// The master modport drives the job and product stream and takes the result.
// The slave modport is the accumulator side.
interface vedic_dot_acc_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8
);
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 s_valid;
    logic                 s_ready;
    logic [2*WIDTH-1:0]   s_product;
    logic                 m_valid;
    logic                 m_ready;
    logic [ACC_WIDTH-1:0] m_result;
    logic                 overflow;
    logic                 busy;

    modport master (
        output start, len, s_valid, s_product, m_ready,
        input  s_ready, m_valid, m_result, overflow, busy
    );

    modport slave (
        input  start, len, s_valid, s_product, m_ready,
        output s_ready, m_valid, m_result, overflow, busy
    );
endinterface

// File: rtl/vedic_dot_acc.sv
// vedic_dot_acc: accumulates a job of LEN unsigned products from the
// multiplier stream into one dot-product result, then offers the result on
// a valid/ready output.
// Optional feature macro: DOT_ACC_SATURATE_EN -- when defined, the
// accumulator clamps to all-ones on overflow for the rest of the job;
// when undefined, it wraps. overflow is set the same way in both builds.
// dbg_state exposes the FSM state (0=IDLE, 1=ACCUM, 2=DONE).
module vedic_dot_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LEN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    vedic_dot_acc_if.slave      bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 ovf;
    logic                 s_ready_r;
    logic                 m_valid_r;
    logic                 busy_r;

    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] next_acc;
    logic                 beat;

    // Sum one bit wider than the accumulator so the carry-out is visible.
    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, bus.s_product};
        next_acc = sum[ACC_WIDTH-1:0];
`ifdef DOT_ACC_SATURATE_EN
        // Once clamped, stay clamped until the job ends.
        if (sum[ACC_WIDTH] || ovf) begin
            next_acc = {ACC_WIDTH{1'b1}};
        end
`endif
    end

    assign beat = bus.s_valid && s_ready_r;

    // Job FSM; the handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= '0;
                        ovf    <= 1'b0;
                        busy_r <= 1'b1;
                        if (bus.len != '0) begin
                            cnt       <= bus.len;
                            state     <= ACCUM;
                            s_ready_r <= 1'b1;
                        end else begin
                            // Empty job: result 0 offered immediately.
                            state     <= DONE;
                            m_valid_r <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= next_acc;
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (sum[ACC_WIDTH]) begin
                            ovf <= 1'b1;
                        end
                        if (cnt == LEN_WIDTH'(1)) begin
                            state     <= DONE;
                            s_ready_r <= 1'b0;
                            m_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        state     <= IDLE;
                        m_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    s_ready_r <= 1'b0;
                    m_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready  = s_ready_r;
    assign bus.m_valid  = m_valid_r;
    assign bus.m_result = acc;
    assign bus.overflow = ovf;
    assign bus.busy     = busy_r;
    assign dbg_state    = state;

endmodule

// File: tb/tb_vedic_dot_acc.sv
// Directed bench for vedic_dot_acc with a 16-bit accumulator so that the
// overflow corner is reachable with two products.
module tb_vedic_dot_acc;

    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int LEN_WIDTH = 8;
    localparam int BOUND     = 50;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    vedic_dot_acc_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    vedic_dot_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [ACC_WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [LEN_WIDTH-1:0]  len;
        logic [2*WIDTH-1:0]    prod [4];
        logic [ACC_WIDTH-1:0]  res;
        logic                  ovf;
    } vec_t;

    vec_t vecs [6];

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [LEN_WIDTH-1:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Offers one product and returns 1 ns after the edge that accepted it.
    task automatic drive_beat(input logic [2*WIDTH-1:0] p);
        logic taken;
        taken = 1'b0;
        for (int i = 0; i < BOUND && !taken; i++) begin
            @(negedge clk);
            bus.s_valid   = 1'b1;
            bus.s_product = p;
            taken         = bus.s_ready;
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        if (!taken) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits for m_valid, compares against the queue head, then accepts it.
    task automatic collect(input string name, input logic exp_ovf);
        logic seen;
        logic [ACC_WIDTH-1:0] exp_res;
        seen = 1'b0;
        for (int i = 0; i < BOUND && !seen; i++) begin
            @(negedge clk);
            seen = bus.m_valid;
        end
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (!seen) begin
            check({name, "_mvalid_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_result"}, 32'(bus.m_result), 32'(exp_res));
            check({name, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
            bus.m_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.m_ready = 1'b0;
            check({name, "_mvalid_drop"}, 32'(bus.m_valid), 32'd0);
            check({name, "_busy_drop"}, 32'(bus.busy), 32'd0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.s_valid   = 1'b0;
        bus.s_product = '0;
        bus.m_ready   = 1'b0;

        vecs[0] = '{len: 8'd3, prod: '{16'd10, 16'd20, 16'd30, 16'd0}, res: 16'd60, ovf: 1'b0};
        vecs[1] = '{len: 8'd1, prod: '{16'd9, 16'd0, 16'd0, 16'd0}, res: 16'd9, ovf: 1'b0};
`ifdef DOT_ACC_SATURATE_EN
        vecs[2] = '{len: 8'd2, prod: '{16'hFFFF, 16'h0002, 16'd0, 16'd0}, res: 16'hFFFF, ovf: 1'b1};
        vecs[4] = '{len: 8'd2, prod: '{16'h8000, 16'h8000, 16'd0, 16'd0}, res: 16'hFFFF, ovf: 1'b1};
        vecs[5] = '{len: 8'd3, prod: '{16'hFFFF, 16'h0001, 16'h0005, 16'd0}, res: 16'hFFFF, ovf: 1'b1};
`else
        vecs[2] = '{len: 8'd2, prod: '{16'hFFFF, 16'h0002, 16'd0, 16'd0}, res: 16'h0001, ovf: 1'b1};
        vecs[4] = '{len: 8'd2, prod: '{16'h8000, 16'h8000, 16'd0, 16'd0}, res: 16'h0000, ovf: 1'b1};
        vecs[5] = '{len: 8'd3, prod: '{16'hFFFF, 16'h0001, 16'h0005, 16'd0}, res: 16'h0005, ovf: 1'b1};
`endif
        vecs[3] = '{len: 8'd4, prod: '{16'd100, 16'd200, 16'd300, 16'd400}, res: 16'd1000, ovf: 1'b0};

        // Reset state
        idle_cycles(2);
        check("rst_s_ready",  32'(bus.s_ready),  32'd0);
        check("rst_m_valid",  32'(bus.m_valid),  32'd0);
        check("rst_m_result", 32'(bus.m_result), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_state",    32'(dbg_state),    32'd0);
        rst = 1'b0;
        idle_cycles(1);

        // Table-driven jobs, products back-to-back
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].res);
            start_job(vecs[v].len);
            check("job_busy", 32'(bus.busy), 32'd1);
            for (int b = 0; b < int'(vecs[v].len); b++) begin
                drive_beat(vecs[v].prod[b]);
            end
            check("job_latency_mvalid", 32'(bus.m_valid), 32'd1);
            check("job_sready_low", 32'(bus.s_ready), 32'd0);
            collect($sformatf("vec%0d", v), vecs[v].ovf);
            idle_cycles(1);
        end

        // Empty job: m_valid next cycle, s_ready never rises
        exp_q.push_back('0);
        start_job('0);
        check("empty_mvalid", 32'(bus.m_valid), 32'd1);
        check("empty_sready", 32'(bus.s_ready), 32'd0);
        check("empty_state",  32'(dbg_state),   32'd2);
        collect("empty", 1'b0);
        idle_cycles(1);

        // Stalls in s_valid and backpressure on m_ready
        exp_q.push_back(16'd12);
        start_job(8'd2);
        drive_beat(16'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_mvalid", 32'(bus.m_valid), 32'd0);
            check("stall_sready", 32'(bus.s_ready), 32'd1);
        end
        drive_beat(16'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_mvalid", 32'(bus.m_valid), 32'd1);
            check("bp_result", 32'(bus.m_result), 32'd12);
            check("bp_overflow", 32'(bus.overflow), 32'd0);
        end
        collect("backpressure", 1'b0);
        idle_cycles(1);

        // Reset mid-job aborts it asynchronously
        start_job(8'd4);
        drive_beat(16'd11);
        drive_beat(16'd13);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_s_ready",  32'(bus.s_ready),  32'd0);
        check("abort_m_valid",  32'(bus.m_valid),  32'd0);
        check("abort_m_result", 32'(bus.m_result), 32'd0);
        check("abort_busy",     32'(bus.busy),     32'd0);
        check("abort_state",    32'(dbg_state),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);
        check("abort_no_mvalid", 32'(bus.m_valid), 32'd0);
        exp_q.push_back(16'd9);
        start_job(8'd1);
        drive_beat(16'd9);
        collect("after_abort", 1'b0);
        idle_cycles(1);

        // start while in ACCUM and DONE is ignored
        exp_q.push_back(16'd7);
        start_job(8'd2);
        drive_beat(16'd3);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drive_beat(16'd4);
        check("ign_accum_mvalid", 32'(bus.m_valid), 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 8'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ign_done_mvalid", 32'(bus.m_valid), 32'd1);
        check("ign_done_result", 32'(bus.m_result), 32'd7);
        collect("start_ignored", 1'b0);
        idle_cycles(2);
        check("ign_final_idle", 32'(dbg_state), 32'd0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
